// File: rtl/reg_file_hilo_if.sv
// rtl/reg_file_hilo_if.sv - operand/write-back bus between control, ALU and reg_file_hilo
//
// Purpose: bundles the read ports, GPR write port, HI/LO load port and flag
// load port of the architectural state block.
// Ports (modport master = controller/ALU side, slave = reg_file_hilo):
//   S_Addr, T_Addr      read indices            (master -> slave)
//   S, T                read data, bypassed     (slave -> master)
//   D_En, D_Addr, D     GPR write port          (master -> slave)
//   HILO_ld, Y_hi, Y_lo HI/LO load port         (master -> slave)
//   HI, LO              HI/LO registers         (slave -> master)
//   FLG_ld, N_in..C_in  flag load port          (master -> slave)
//   N, Z, V, C          registered flags        (slave -> master)
interface reg_file_hilo_if;
  logic [4:0]  S_Addr;
  logic [4:0]  T_Addr;
  logic [31:0] S;
  logic [31:0] T;
  logic        D_En;
  logic [4:0]  D_Addr;
  logic [31:0] D;
  logic        HILO_ld;
  logic [31:0] Y_hi;
  logic [31:0] Y_lo;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        FLG_ld;
  logic        N_in;
  logic        Z_in;
  logic        V_in;
  logic        C_in;
  logic        N;
  logic        Z;
  logic        V;
  logic        C;

  modport master (
    output S_Addr, T_Addr, D_En, D_Addr, D, HILO_ld, Y_hi, Y_lo,
           FLG_ld, N_in, Z_in, V_in, C_in,
    input  S, T, HI, LO, N, Z, V, C
  );

  modport slave (
    input  S_Addr, T_Addr, D_En, D_Addr, D, HILO_ld, Y_hi, Y_lo,
           FLG_ld, N_in, Z_in, V_in, C_in,
    output S, T, HI, LO, N, Z, V, C
  );
endinterface

// File: rtl/reg_file_hilo.sv
// rtl/reg_file_hilo.sv - MIPS GPR file with HI/LO pair and NZVC status register
//
// Purpose: holds the 31 writable general-purpose registers (register 0 is
// hardwired to zero), the HI/LO result pair and the 4-bit status register.
// Reads are combinational with same-cycle write bypass; all writes happen on
// the rising clock edge.
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous, active-high; overrides every enable in its cycle
//   bus    reg_file_hilo_if.slave (read ports, write port, HI/LO, flags)
// Parameters:
//   RST_SP reset value of register 29 (stack pointer)
module reg_file_hilo #(
  parameter logic [31:0] RST_SP = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  reg_file_hilo_if.slave   bus
);

  // Index 0 has no storage; it is never written and always reads zero.
  logic [31:0] gpr_q [1:31];
  logic [31:0] gpr_d [1:31];
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [3:0]  flg_q, flg_d;    // {N, Z, V, C}

  logic        gpr_wr;
  logic [31:0] s_rd;
  logic [31:0] t_rd;

  // A write to index 0 is discarded, so it must not drive the bypass either.
  assign gpr_wr = bus.D_En && (bus.D_Addr != 5'd0);

  always_comb begin
    gpr_d = gpr_q;
    for (int i = 1; i < 32; i++) begin
      if (gpr_wr && (bus.D_Addr == i[4:0])) begin
        gpr_d[i] = bus.D;
      end
    end
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (bus.HILO_ld) begin
      hi_d = bus.Y_hi;
      lo_d = bus.Y_lo;
    end
  end

  // Flag inputs are captured as-is, including x, so control must only load
  // flags for ALU functions where every flag is meaningful.
  always_comb begin
    flg_d = flg_q;
    if (bus.FLG_ld) begin
      flg_d = {bus.N_in, bus.Z_in, bus.V_in, bus.C_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        gpr_q[i] <= (i == 29) ? RST_SP : 32'h0;
      end
      hi_q  <= 32'h0;
      lo_q  <= 32'h0;
      flg_q <= 4'b0000;
    end else begin
      gpr_q <= gpr_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      flg_q <= flg_d;
    end
  end

  // Read muxes: stored value first, then the in-flight write overrides it.
  always_comb begin
    s_rd = 32'h0;
    t_rd = 32'h0;
    for (int i = 1; i < 32; i++) begin
      if (bus.S_Addr == i[4:0]) begin
        s_rd = gpr_q[i];
      end
      if (bus.T_Addr == i[4:0]) begin
        t_rd = gpr_q[i];
      end
    end
    if (gpr_wr && (bus.S_Addr == bus.D_Addr)) begin
      s_rd = bus.D;
    end
    if (gpr_wr && (bus.T_Addr == bus.D_Addr)) begin
      t_rd = bus.D;
    end
  end

  assign bus.S  = s_rd;
  assign bus.T  = t_rd;
  assign bus.HI = hi_q;
  assign bus.LO = lo_q;
  assign bus.N  = flg_q[3];
  assign bus.Z  = flg_q[2];
  assign bus.V  = flg_q[1];
  assign bus.C  = flg_q[0];

endmodule

// File: tb/tb_reg_file_hilo.sv
// tb/tb_reg_file_hilo.sv - directed self-checking bench for reg_file_hilo
module tb_reg_file_hilo;

  localparam logic [31:0] SP_INIT = 32'h7FFF_FFF0;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  reg_file_hilo_if bus ();

  reg_file_hilo #(.RST_SP(SP_INIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.S_Addr  = 5'd0;
    bus.T_Addr  = 5'd0;
    bus.D_En    = 1'b0;
    bus.D_Addr  = 5'd0;
    bus.D       = 32'h0;
    bus.HILO_ld = 1'b0;
    bus.Y_hi    = 32'h0;
    bus.Y_lo    = 32'h0;
    bus.FLG_ld  = 1'b0;
    bus.N_in    = 1'b0;
    bus.Z_in    = 1'b0;
    bus.V_in    = 1'b0;
    bus.C_in    = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.D_En = 1'b1; bus.D_Addr = 5'd5; bus.D = 32'hCAFE_F00D;
    bus.HILO_ld = 1'b1; bus.Y_hi = 32'h1111_1111; bus.Y_lo = 32'h2222_2222;
    bus.FLG_ld = 1'b1; bus.N_in = 1'b1; bus.Z_in = 1'b1; bus.V_in = 1'b1; bus.C_in = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    #1;
    checks++; if (bus.HI !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want %h", bus.HI, 32'h0); end
    checks++; if (bus.LO !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want %h", bus.LO, 32'h0); end
    checks++; if ({bus.N, bus.Z, bus.V, bus.C} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {bus.N, bus.Z, bus.V, bus.C}); end
    checks++; if ({bus.S, bus.T} !== 64'h0) begin errors++; $display("FAIL reset_default_addr: got S=%h T=%h want 0", bus.S, bus.T); end
    bus.S_Addr = 5'd29; bus.T_Addr = 5'd5;
    #1;
    checks++; if (bus.S !== SP_INIT) begin errors++; $display("FAIL reset_sp: got %h want %h", bus.S, SP_INIT); end
    checks++; if (bus.T !== 32'h0) begin errors++; $display("FAIL reset_r5: got %h want %h", bus.T, 32'h0); end
  endtask

  task automatic test_write_read();
    logic [31:0] exp_s;
    logic [31:0] exp_t;
    for (int i = 1; i < 32; i++) begin
      bus.D_En = 1'b1; bus.D_Addr = i[4:0]; bus.D = 32'hA5A5_0000 + i;
      tick();
    end
    bus.D_Addr = 5'd0; bus.D = 32'hFFFF_FFFF;
    tick();
    bus.D_En = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.S_Addr = i[4:0];
      bus.T_Addr = 5'(31 - i);
      #1;
      exp_s = (i == 0) ? 32'h0 : 32'hA5A5_0000 + i;
      exp_t = (i == 31) ? 32'h0 : 32'hA5A5_0000 + (31 - i);
      checks++; if (bus.S !== exp_s) begin errors++; $display("FAIL rd_s[%0d]: got %h want %h", i, bus.S, exp_s); end
      checks++; if (bus.T !== exp_t) begin errors++; $display("FAIL rd_t[%0d]: got %h want %h", 31 - i, bus.T, exp_t); end
    end
  endtask

  task automatic test_bypass();
    bus.D_En = 1'b1; bus.D_Addr = 5'd7; bus.D = 32'h1234_5678;
    bus.S_Addr = 5'd7; bus.T_Addr = 5'd7;
    #1;
    checks++; if (bus.S !== 32'h1234_5678) begin errors++; $display("FAIL bypass_s: got %h want %h", bus.S, 32'h1234_5678); end
    checks++; if (bus.T !== 32'h1234_5678) begin errors++; $display("FAIL bypass_t: got %h want %h", bus.T, 32'h1234_5678); end
    bus.D_Addr = 5'd0; bus.D = 32'h0000_DEAD; bus.S_Addr = 5'd0;
    #1;
    checks++; if (bus.S !== 32'h0) begin errors++; $display("FAIL bypass_r0: got %h want %h", bus.S, 32'h0); end
    checks++; if (bus.T !== 32'hA5A5_0007) begin errors++; $display("FAIL bypass_r0_no_t: got %h want %h", bus.T, 32'hA5A5_0007); end
    tick();
    bus.D_En = 1'b0;
    #1;
    checks++; if (bus.S !== 32'h0) begin errors++; $display("FAIL r0_after_write: got %h want %h", bus.S, 32'h0); end
    checks++; if (bus.T !== 32'hA5A5_0007) begin errors++; $display("FAIL r7_kept: got %h want %h", bus.T, 32'hA5A5_0007); end
  endtask

  task automatic test_hilo();
    bus.HILO_ld = 1'b1; bus.Y_hi = 32'h1; bus.Y_lo = 32'hFFFF_FFFE;
    #1;
    checks++; if (bus.HI !== 32'h0) begin errors++; $display("FAIL hi_no_bypass: got %h want %h", bus.HI, 32'h0); end
    tick();
    bus.HILO_ld = 1'b0; bus.Y_hi = 32'h9999_9999; bus.Y_lo = 32'h8888_8888;
    #1;
    checks++; if (bus.HI !== 32'h1) begin errors++; $display("FAIL hi_load: got %h want %h", bus.HI, 32'h1); end
    checks++; if (bus.LO !== 32'hFFFF_FFFE) begin errors++; $display("FAIL lo_load: got %h want %h", bus.LO, 32'hFFFF_FFFE); end
    tick();
    checks++; if (bus.HI !== 32'h1) begin errors++; $display("FAIL hi_hold: got %h want %h", bus.HI, 32'h1); end
    checks++; if (bus.LO !== 32'hFFFF_FFFE) begin errors++; $display("FAIL lo_hold: got %h want %h", bus.LO, 32'hFFFF_FFFE); end
  endtask

  task automatic test_simultaneous();
    bus.FLG_ld = 1'b1; bus.N_in = 1'b1; bus.Z_in = 1'b0; bus.V_in = 1'b1; bus.C_in = 1'b1;
    bus.HILO_ld = 1'b1; bus.Y_hi = 32'h0000_AAAA; bus.Y_lo = 32'h0000_BBBB;
    bus.D_En = 1'b1; bus.D_Addr = 5'd3; bus.D = 32'h55;
    tick();
    idle_inputs();
    bus.S_Addr = 5'd3;
    #1;
    checks++; if ({bus.N, bus.Z, bus.V, bus.C} !== 4'b1011) begin errors++; $display("FAIL sim_flags: got %b want 1011", {bus.N, bus.Z, bus.V, bus.C}); end
    checks++; if (bus.HI !== 32'h0000_AAAA) begin errors++; $display("FAIL sim_hi: got %h want %h", bus.HI, 32'h0000_AAAA); end
    checks++; if (bus.LO !== 32'h0000_BBBB) begin errors++; $display("FAIL sim_lo: got %h want %h", bus.LO, 32'h0000_BBBB); end
    checks++; if (bus.S !== 32'h55) begin errors++; $display("FAIL sim_gpr: got %h want %h", bus.S, 32'h55); end
    bus.FLG_ld = 1'b1; bus.N_in = 1'b1; bus.Z_in = 1'b1; bus.V_in = 1'b1; bus.C_in = 1'b1;
    bus.HILO_ld = 1'b1; bus.Y_hi = 32'h1234; bus.Y_lo = 32'h5678;
    bus.D_En = 1'b1; bus.D_Addr = 5'd9; bus.D = 32'hBEEF;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    bus.S_Addr = 5'd3; bus.T_Addr = 5'd9;
    #1;
    checks++; if ({bus.N, bus.Z, bus.V, bus.C} !== 4'b0000) begin errors++; $display("FAIL rst2_flags: got %b want 0000", {bus.N, bus.Z, bus.V, bus.C}); end
    checks++; if ({bus.HI, bus.LO} !== 64'h0) begin errors++; $display("FAIL rst2_hilo: got HI=%h LO=%h want 0", bus.HI, bus.LO); end
    checks++; if (bus.S !== 32'h0) begin errors++; $display("FAIL rst2_r3: got %h want %h", bus.S, 32'h0); end
    checks++; if (bus.T !== 32'h0) begin errors++; $display("FAIL rst2_r9: got %h want %h", bus.T, 32'h0); end
    bus.S_Addr = 5'd29; bus.T_Addr = 5'd31;
    #1;
    checks++; if (bus.S !== SP_INIT) begin errors++; $display("FAIL rst2_sp: got %h want %h", bus.S, SP_INIT); end
    checks++; if (bus.T !== 32'h0) begin errors++; $display("FAIL rst2_r31: got %h want %h", bus.T, 32'h0); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    idle_inputs();
    #2;
    test_reset();
    test_write_read();
    test_bypass();
    test_hilo();
    test_simultaneous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
